// File: rtl/reaction_timer_core.sv
// Purpose: reaction-time game FSM: random arming delay, GO LED, 4-digit BCD count of 10 ms ticks.
// Latency: inputs are edge-detected against a one-clock history; state, led_go and false_start update on the edge that samples the rise.
// Backpressure: none; button and tick levels are consumed every clock. Optional best-time tracking: define BEST_TIME_EN.
module reaction_timer_core #(
  parameter int MIN_DELAY_TICKS = 100,
  parameter int RAND_BITS       = 8
) (
  input  logic        clk_50mhz,
  input  logic        rst_50mhz,
  input  logic        tick_100hz,
  input  logic        start_btn,
  input  logic        react_btn,
  output logic        led_go,
  output logic        false_start,
  output logic        overflow,
  output logic [2:0]  state,
  output logic [15:0] time_bcd,
  output logic [15:0] best_bcd,
  output logic        best_valid
);

  localparam logic [2:0] S_IDLE        = 3'd0;
  localparam logic [2:0] S_ARMED       = 3'd1;
  localparam logic [2:0] S_GO          = 3'd2;
  localparam logic [2:0] S_DONE        = 3'd3;
  localparam logic [2:0] S_FALSE_START = 3'd4;

  localparam logic [15:0] MIN_DELAY_16 = 16'(MIN_DELAY_TICKS);
  localparam int          RAND_MASK_I  = (1 << RAND_BITS) - 1;
  localparam logic [15:0] RAND_MASK    = 16'(RAND_MASK_I);

  // Previous-sample registers reset high so a level already asserted at reset release is not a rise.
  logic tick_prev;
  logic start_prev;
  logic react_prev;
  logic tick_rise;
  logic start_rise;
  logic react_rise;

  logic [15:0] lfsr;
  logic        lfsr_fb;
  logic [15:0] delay_cnt;
  logic [16:0] delay_sum;
  logic [15:0] delay_load;

  logic [2:0]  state_nxt;
  logic        led_go_nxt;
  logic        false_start_nxt;
  logic        arm_load;
  logic        done_by_react;

  // Increment a 4-digit BCD value; a digit at 9 wraps to 0 and carries upward.
  function automatic logic [15:0] bcd_inc(input logic [15:0] v);
    logic [15:0] r;
    logic        carry;
    r     = v;
    carry = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (carry) begin
        if (r[i*4 +: 4] == 4'd9) begin
          r[i*4 +: 4] = 4'd0;
        end else begin
          r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
          carry       = 1'b0;
        end
      end
    end
    return r;
  endfunction

  // Sample the three inputs once per clock for rise detection.
  always_ff @(posedge clk_50mhz) begin
    if (rst_50mhz) begin
      tick_prev  <= 1'b1;
      start_prev <= 1'b1;
      react_prev <= 1'b1;
    end else begin
      tick_prev  <= tick_100hz;
      start_prev <= start_btn;
      react_prev <= react_btn;
    end
  end

  assign tick_rise  = tick_100hz & ~tick_prev;
  assign start_rise = start_btn  & ~start_prev;
  assign react_rise = react_btn  & ~react_prev;

  // Free-running 16-bit Fibonacci LFSR (taps 16,14,13,11); nonzero seed keeps it out of the all-zero lockup.
  assign lfsr_fb = lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10];

  always_ff @(posedge clk_50mhz) begin
    if (rst_50mhz) begin
      lfsr <= 16'hACE1;
    end else begin
      lfsr <= {lfsr[14:0], lfsr_fb};
    end
  end

  // Arming delay: minimum plus the low random bits, saturated rather than wrapped.
  assign delay_sum  = {1'b0, MIN_DELAY_16} + {1'b0, (lfsr & RAND_MASK)};
  assign delay_load = delay_sum[16] ? 16'hFFFF : delay_sum[15:0];

  // A new trial arms from any resting state on a start rise.
  assign arm_load = start_rise &&
                    ((state == S_IDLE) || (state == S_DONE) || (state == S_FALSE_START));

  // A player-stopped trial (not an overflow) is the only source of a best-time candidate.
  assign done_by_react = (state == S_GO) && react_rise;

  // State register.
  always_ff @(posedge clk_50mhz) begin
    if (rst_50mhz) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; react outranks a coincident tick, start outranks a coincident react in DONE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (start_rise) state_nxt = S_ARMED;
      end
      S_ARMED: begin
        if (react_rise) begin
          state_nxt = S_FALSE_START;
        end else if (tick_rise && (delay_cnt <= 16'd1)) begin
          state_nxt = S_GO;
        end
      end
      S_GO: begin
        if (react_rise) begin
          state_nxt = S_DONE;
        end else if (tick_rise && (time_bcd == 16'h9999)) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        if (start_rise) state_nxt = S_ARMED;
      end
      S_FALSE_START: begin
        if (start_rise) state_nxt = S_ARMED;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // LED outputs are decoded from the next state so they change on the same edge as the state.
  always_comb begin
    led_go_nxt      = (state_nxt == S_GO);
    false_start_nxt = (state_nxt == S_FALSE_START);
  end

  // Register the decoded LED outputs.
  always_ff @(posedge clk_50mhz) begin
    if (rst_50mhz) begin
      led_go      <= 1'b0;
      false_start <= 1'b0;
    end else begin
      led_go      <= led_go_nxt;
      false_start <= false_start_nxt;
    end
  end

  // Delay countdown, BCD reaction counter and overflow flag.
  always_ff @(posedge clk_50mhz) begin
    if (rst_50mhz) begin
      delay_cnt <= 16'd0;
      time_bcd  <= 16'h0000;
      overflow  <= 1'b0;
    end else if (arm_load) begin
      delay_cnt <= delay_load;
      time_bcd  <= 16'h0000;
      overflow  <= 1'b0;
    end else begin
      case (state)
        S_ARMED: begin
          if (!react_rise && tick_rise) begin
            delay_cnt <= (delay_cnt == 16'd0) ? 16'd0 : delay_cnt - 16'd1;
            if (delay_cnt <= 16'd1) time_bcd <= 16'h0000;
          end
        end
        S_GO: begin
          if (!react_rise && tick_rise) begin
            if (time_bcd == 16'h9999) begin
              overflow <= 1'b1;
            end else begin
              time_bcd <= bcd_inc(time_bcd);
            end
          end
        end
        S_FALSE_START: begin
          time_bcd <= 16'h0000;
        end
        default: begin
          time_bcd <= time_bcd;
        end
      endcase
    end
  end

`ifdef BEST_TIME_EN
  // Keep the fastest completed time; packed BCD orders the same as binary, so a plain compare works.
  always_ff @(posedge clk_50mhz) begin
    if (rst_50mhz) begin
      best_bcd   <= 16'h9999;
      best_valid <= 1'b0;
    end else if (done_by_react && (time_bcd < best_bcd)) begin
      best_bcd   <= time_bcd;
      best_valid <= 1'b1;
    end
  end
`else
  assign best_bcd   = 16'h9999;
  assign best_valid = 1'b0;
  logic unused_best;
  assign unused_best = done_by_react;
`endif

endmodule

// File: tb/tb_reaction_timer_core.sv
// Bench for reaction_timer_core with a short arming delay (3 + one random bit ticks).
// Inputs change on the falling clock edge and outputs are sampled there too.
// Expected best-time values follow the BEST_TIME_EN setting of the build.
module tb_reaction_timer_core;

  logic        clk_50mhz = 1'b0;
  logic        rst_50mhz = 1'b1;
  logic        tick_100hz = 1'b0;
  logic        start_btn = 1'b0;
  logic        react_btn = 1'b0;
  logic        led_go;
  logic        false_start;
  logic        overflow;
  logic [2:0]  state;
  logic [15:0] time_bcd;
  logic [15:0] best_bcd;
  logic        best_valid;

  int errors = 0;
  int checks = 0;

  typedef struct {
    int          ticks;
    logic [15:0] exp_time;
    logic [15:0] exp_best;
    logic        exp_valid;
  } trial_t;

  trial_t tv[10];

  logic [15:0] final_best;
  logic        final_valid;

  reaction_timer_core #(
    .MIN_DELAY_TICKS(3),
    .RAND_BITS(1)
  ) dut (
    .clk_50mhz(clk_50mhz),
    .rst_50mhz(rst_50mhz),
    .tick_100hz(tick_100hz),
    .start_btn(start_btn),
    .react_btn(react_btn),
    .led_go(led_go),
    .false_start(false_start),
    .overflow(overflow),
    .state(state),
    .time_bcd(time_bcd),
    .best_bcd(best_bcd),
    .best_valid(best_valid)
  );

  always #10 clk_50mhz = ~clk_50mhz;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick_pulse();
    @(negedge clk_50mhz) tick_100hz = 1'b1;
    @(negedge clk_50mhz) tick_100hz = 1'b0;
  endtask

  task automatic start_pulse();
    @(negedge clk_50mhz) start_btn = 1'b1;
    @(negedge clk_50mhz) start_btn = 1'b0;
  endtask

  task automatic react_pulse();
    @(negedge clk_50mhz) react_btn = 1'b1;
    @(negedge clk_50mhz) react_btn = 1'b0;
  endtask

  // Tick until GO, bounded; the arming delay must be 3 or 4 ticks.
  task automatic wait_go(input string name);
    int n;
    n = 0;
    while (state !== 3'd2 && n < 10) begin
      tick_pulse();
      n++;
    end
    checks++;
    if (state !== 3'd2 || n < 3 || n > 4) begin
      errors++;
      $display("FAIL %s_go_delay: ticks=%0d state=%0d expected 3..4 ticks to state 2", name, n, state);
    end
    chk({name, "_go_led"}, 32'(led_go), 32'd1);
    chk({name, "_go_time"}, 32'(time_bcd), 32'h0000);
  endtask

  initial begin
`ifdef BEST_TIME_EN
    tv[0] = '{250,  16'h0250, 16'h0250, 1'b1};
    tv[1] = '{180,  16'h0180, 16'h0180, 1'b1};
    tv[2] = '{300,  16'h0300, 16'h0180, 1'b1};
    tv[3] = '{999,  16'h0999, 16'h0180, 1'b1};
    tv[4] = '{1000, 16'h1000, 16'h0180, 1'b1};
    tv[5] = '{37,   16'h0037, 16'h0037, 1'b1};
    tv[6] = '{9,    16'h0009, 16'h0009, 1'b1};
    tv[7] = '{10,   16'h0010, 16'h0009, 1'b1};
    tv[8] = '{99,   16'h0099, 16'h0009, 1'b1};
    tv[9] = '{100,  16'h0100, 16'h0009, 1'b1};
    final_best  = 16'h0009;
    final_valid = 1'b1;
`else
    tv[0] = '{250,  16'h0250, 16'h9999, 1'b0};
    tv[1] = '{180,  16'h0180, 16'h9999, 1'b0};
    tv[2] = '{300,  16'h0300, 16'h9999, 1'b0};
    tv[3] = '{999,  16'h0999, 16'h9999, 1'b0};
    tv[4] = '{1000, 16'h1000, 16'h9999, 1'b0};
    tv[5] = '{37,   16'h0037, 16'h9999, 1'b0};
    tv[6] = '{9,    16'h0009, 16'h9999, 1'b0};
    tv[7] = '{10,   16'h0010, 16'h9999, 1'b0};
    tv[8] = '{99,   16'h0099, 16'h9999, 1'b0};
    tv[9] = '{100,  16'h0100, 16'h9999, 1'b0};
    final_best  = 16'h9999;
    final_valid = 1'b0;
`endif

    // Reset with tick and start held high through release: neither may register a rise.
    rst_50mhz  = 1'b1;
    tick_100hz = 1'b1;
    start_btn  = 1'b1;
    repeat (4) @(negedge clk_50mhz);
    rst_50mhz = 1'b0;
    repeat (3) @(negedge clk_50mhz);
    chk("rst_state", 32'(state), 32'd0);
    chk("rst_time", 32'(time_bcd), 32'h0000);
    chk("rst_led_go", 32'(led_go), 32'd0);
    chk("rst_false_start", 32'(false_start), 32'd0);
    chk("rst_overflow", 32'(overflow), 32'd0);
    chk("rst_best", 32'(best_bcd), 32'h9999);
    chk("rst_best_valid", 32'(best_valid), 32'd0);
    tick_100hz = 1'b0;
    start_btn  = 1'b0;
    @(negedge clk_50mhz);

    // Table of complete trials, including BCD carry boundaries and the best-time sequence.
    for (int i = 0; i < 10; i++) begin
      start_pulse();
      chk($sformatf("t%0d_armed", i), 32'(state), 32'd1);
      chk($sformatf("t%0d_arm_time", i), 32'(time_bcd), 32'h0000);
      wait_go($sformatf("t%0d", i));
      for (int k = 0; k < tv[i].ticks; k++) tick_pulse();
      react_pulse();
      chk($sformatf("t%0d_done", i), 32'(state), 32'd3);
      chk($sformatf("t%0d_time", i), 32'(time_bcd), 32'(tv[i].exp_time));
      chk($sformatf("t%0d_led_off", i), 32'(led_go), 32'd0);
      chk($sformatf("t%0d_ovf", i), 32'(overflow), 32'd0);
      chk($sformatf("t%0d_best", i), 32'(best_bcd), 32'(tv[i].exp_best));
      chk($sformatf("t%0d_best_valid", i), 32'(best_valid), 32'(tv[i].exp_valid));
    end

    // Time frozen in DONE while ticks keep arriving.
    repeat (3) tick_pulse();
    chk("done_hold", 32'(time_bcd), 32'h0100);

    // False start, then re-arm from FALSE_START.
    start_pulse();
    react_pulse();
    chk("fs_state", 32'(state), 32'd4);
    chk("fs_flag", 32'(false_start), 32'd1);
    chk("fs_time", 32'(time_bcd), 32'h0000);
    chk("fs_led", 32'(led_go), 32'd0);
    start_pulse();
    chk("fs_rearm_state", 32'(state), 32'd1);
    chk("fs_rearm_flag", 32'(false_start), 32'd0);
    wait_go("fs");
    repeat (20) tick_pulse();
    react_pulse();
    chk("fs_trial_time", 32'(time_bcd), 32'h0020);
    chk("fs_best", 32'(best_bcd), 32'(final_best));

    // React and tick rise together at 0012: react wins, the tick is not counted.
    start_pulse();
    wait_go("coin");
    repeat (12) tick_pulse();
    @(negedge clk_50mhz);
    tick_100hz = 1'b1;
    react_btn  = 1'b1;
    @(negedge clk_50mhz);
    tick_100hz = 1'b0;
    react_btn  = 1'b0;
    chk("coin_state", 32'(state), 32'd3);
    chk("coin_time", 32'(time_bcd), 32'h0012);

    // Saturation at 99.99 s.
    start_pulse();
    wait_go("ovf");
    repeat (9999) tick_pulse();
    chk("ovf_pre_time", 32'(time_bcd), 32'h9999);
    chk("ovf_pre_state", 32'(state), 32'd2);
    chk("ovf_pre_flag", 32'(overflow), 32'd0);
    tick_pulse();
    chk("ovf_time", 32'(time_bcd), 32'h9999);
    chk("ovf_flag", 32'(overflow), 32'd1);
    chk("ovf_state", 32'(state), 32'd3);
    chk("ovf_led", 32'(led_go), 32'd0);
    chk("ovf_best", 32'(best_bcd), 32'(final_best));
    chk("ovf_best_valid", 32'(best_valid), 32'(final_valid));

    // Start and react rise together in DONE: start wins and clears the trial.
    @(negedge clk_50mhz);
    start_btn = 1'b1;
    react_btn = 1'b1;
    @(negedge clk_50mhz);
    start_btn = 1'b0;
    react_btn = 1'b0;
    chk("sr_state", 32'(state), 32'd1);
    chk("sr_time", 32'(time_bcd), 32'h0000);
    chk("sr_ovf", 32'(overflow), 32'd0);

    // Reset in the middle of a GO count.
    wait_go("mid");
    repeat (5) tick_pulse();
    chk("mid_time", 32'(time_bcd), 32'h0005);
    @(negedge clk_50mhz) rst_50mhz = 1'b1;
    @(negedge clk_50mhz) rst_50mhz = 1'b0;
    chk("mid_rst_state", 32'(state), 32'd0);
    chk("mid_rst_time", 32'(time_bcd), 32'h0000);
    chk("mid_rst_led", 32'(led_go), 32'd0);
    chk("mid_rst_best", 32'(best_bcd), 32'h9999);
    chk("mid_rst_best_valid", 32'(best_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
